cpu_ctrl_fsm: RTL and testbench

- Multi-cycle sequencing controller for the single-issue CPU `top`.
- Drives IM fetch handshake, PC, instruction register load, regfile read/write strobes, ALU enable and DM read/write handshake.
- Each instruction occupies a fixed 8-cycle slot, matching IR_CYCLE = 8.
- Sits directly upstream of IM/DM and the regfile/ALU datapath; also owns the instruction and cycle counters.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/cpu_opdec.sv | 52 +++++
 rtl/cpu_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller and datapath.
//   state_e  : sequencer state encoding (one instruction = F0..WB, 8 cycles)
//   iclass_e : instruction class produced by the opcode decoder
//   OP_*     : 6-bit primary opcodes found in ir[30:25]
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    F0   = 4'd1,
    F1   = 4'd2,
    DEC  = 4'd3,
    RD   = 4'd4,
    EX   = 4'd5,
    M0   = 4'd6,
    M1   = 4'd7,
    WB   = 4'd8,
    HALT = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    C_ALU = 2'd0,
    C_IMM = 2'd1,
    C_LD  = 2'd2,
    C_ST  = 2'd3
  } iclass_e;

  localparam logic [5:0] OP_ALU_1 = 6'b100000;
  localparam logic [5:0] OP_MOVI  = 6'b100010;
  localparam logic [5:0] OP_ADDI  = 6'b101000;
  localparam logic [5:0] OP_ORI   = 6'b101100;
  localparam logic [5:0] OP_XORI  = 6'b101011;
  localparam logic [5:0] OP_LWI   = 6'b000010;
  localparam logic [5:0] OP_SWI   = 6'b001010;

endpackage

// File: rtl/cpu_opdec.sv
// Combinational opcode decoder, shared by the controller and the datapath.
// Ports:
//   op_field  in  7  ir[31:25] (bit 6 must be 0 for a legal instruction)
//   ins_class out 2  iclass_e value (C_ALU/C_IMM/C_LD/C_ST)
//   legal     out 1  opcode is one of the supported encodings
//   imm_sel   out 1  ALU operand B comes from the immediate field
//   wb_sel    out 1  write-back source is the MDR (loads)
module cpu_opdec
  import cpu_pkg::*;
(
  input  logic [6:0] op_field,
  output logic [1:0] ins_class,
  output logic       legal,
  output logic       imm_sel,
  output logic       wb_sel
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    ins_class = C_ALU;
    legal     = 1'b0;
    imm_sel   = 1'b0;
    wb_sel    = 1'b0;
    if (!op_field[6]) begin
      unique case (op_field[5:0])
        OP_ALU_1: begin
          ins_class = C_ALU;
          legal     = 1'b1;
        end
        OP_MOVI, OP_ADDI, OP_ORI, OP_XORI: begin
          ins_class = C_IMM;
          legal     = 1'b1;
          imm_sel   = 1'b1;
        end
        OP_LWI: begin
          ins_class = C_LD;
          legal     = 1'b1;
          imm_sel   = 1'b1;
          wb_sel    = 1'b1;
        end
        OP_SWI: begin
          ins_class = C_ST;
          legal     = 1'b1;
          imm_sel   = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle sequencing controller for the single-issue CPU.
// Every instruction occupies a fixed 8-cycle slot F0 F1 DEC RD EX M0 M1 WB.
// An illegal opcode parks the machine in HALT until reset.
// Ports:
//   clk, rst (async, active-low)
//   instruction  in   IM read data, valid the cycle after IM_read
//   IM_*         out  instruction-memory handshake; IM_address = PC
//   ir           out  latched instruction
//   imm_sel, wb_sel   operand-B / write-back source, valid DEC..WB
//   rf_read, alu_en, rf_write      datapath strobes
//   DM_enable, DM_read, DM_write, dm_load   data-memory handshake
//   halted       out  sticky illegal-instruction flag
//   Ins_cnt, Cycle_cnt  retired instructions / cycles since reset release
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int IMAddrSize = 10,
  parameter int InsSize    = 64,
  parameter int CycSize    = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  output logic                  IM_enable,
  output logic                  IM_read,
  output logic                  IM_write,
  output logic [IMAddrSize-1:0] IM_address,
  output logic [31:0]           ir,
  output logic                  imm_sel,
  output logic                  rf_read,
  output logic                  alu_en,
  output logic                  DM_enable,
  output logic                  DM_read,
  output logic                  DM_write,
  output logic                  dm_load,
  output logic                  rf_write,
  output logic                  wb_sel,
  output logic                  halted,
  output logic [InsSize-1:0]    Ins_cnt,
  output logic [CycSize-1:0]    Cycle_cnt
);

  state_e                state_q, state_d;
  logic [IMAddrSize-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [InsSize-1:0]    ins_cnt_q, ins_cnt_d;
  logic [CycSize-1:0]    cycle_cnt_q, cycle_cnt_d;

  logic [1:0] dec_class;
  logic       dec_legal;
  logic       dec_imm_sel;
  logic       dec_wb_sel;
  logic       in_slot;
  logic       is_ld;
  logic       is_st;

  cpu_opdec u_opdec (
    .op_field  (ir_q[31:25]),
    .ins_class (dec_class),
    .legal     (dec_legal),
    .imm_sel   (dec_imm_sel),
    .wb_sel    (dec_wb_sel)
  );

  // Next state, PC, IR and counters.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ins_cnt_d   = ins_cnt_q;
    cycle_cnt_d = cycle_cnt_q + 1'b1;  // counts in every state, HALT included
    unique case (state_q)
      IDLE: state_d = F0;
      F0:   state_d = F1;
      F1: begin
        state_d = DEC;
        ir_d    = instruction;
      end
      DEC:  state_d = dec_legal ? RD : HALT;
      RD:   state_d = EX;
      EX:   state_d = M0;
      M0:   state_d = M1;
      M1:   state_d = WB;
      WB: begin
        state_d   = F0;
        pc_d      = pc_q + 1'b1;  // wraps at 2^IMAddrSize
        ins_cnt_d = ins_cnt_q + 1'b1;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      ins_cnt_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ins_cnt_q   <= ins_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Moore strobes decoded from the registered state. Because reset forces
  // IDLE asynchronously, every strobe drops the moment rst goes low.
  always_comb begin
    IM_enable = 1'b0;
    IM_read   = 1'b0;
    rf_read   = 1'b0;
    alu_en    = 1'b0;
    DM_enable = 1'b0;
    DM_read   = 1'b0;
    DM_write  = 1'b0;
    dm_load   = 1'b0;
    rf_write  = 1'b0;
    in_slot   = state_q inside {DEC, RD, EX, M0, M1, WB};
    is_ld     = (dec_class == C_LD);
    is_st     = (dec_class == C_ST);
    imm_sel   = in_slot & dec_imm_sel;
    wb_sel    = in_slot & dec_wb_sel;
    halted    = (state_q == HALT);
    unique case (state_q)
      F0: begin
        IM_enable = 1'b1;
        IM_read   = 1'b1;
      end
      F1: IM_enable = 1'b1;
      RD: rf_read = 1'b1;
      EX: alu_en = 1'b1;
      M0: begin
        DM_enable = is_ld | is_st;
        DM_read   = is_ld;
        DM_write  = is_st;
      end
      M1: begin
        // Stores keep the DM selected one extra cycle; only loads capture.
        DM_enable = is_ld | is_st;
        dm_load   = is_ld;
      end
      WB: rf_write = ~is_st;
      default: ;
    endcase
  end

  assign IM_write   = 1'b0;
  assign IM_address = pc_q;
  assign ir         = ir_q;
  assign Ins_cnt    = ins_cnt_q;
  assign Cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;

  localparam int PH_HALT = 8;
  localparam int PH_IDLE = 9;
  localparam int K_ILL = 0;
  localparam int K_ALU = 1;
  localparam int K_IMM = 2;
  localparam int K_LD  = 3;
  localparam int K_ST  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  instruction;
  logic         IM_enable, IM_read, IM_write;
  logic [9:0]   IM_address;
  logic [31:0]  ir;
  logic         imm_sel, rf_read, alu_en, DM_enable, DM_read, DM_write;
  logic         dm_load, rf_write, wb_sel, halted;
  logic [63:0]  Ins_cnt;
  logic [127:0] Cycle_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] im_q;

  // Reference model: slot phase 0..7 = F0..WB, plus HALT / IDLE.
  int           m_ph;
  logic [9:0]   m_pc;
  logic [31:0]  m_ir;
  logic [63:0]  m_ins;
  logic [127:0] m_cyc;

  cpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .IM_enable(IM_enable), .IM_read(IM_read), .IM_write(IM_write),
    .IM_address(IM_address), .ir(ir), .imm_sel(imm_sel), .rf_read(rf_read),
    .alu_en(alu_en), .DM_enable(DM_enable), .DM_read(DM_read),
    .DM_write(DM_write), .dm_load(dm_load), .rf_write(rf_write),
    .wb_sel(wb_sel), .halted(halted), .Ins_cnt(Ins_cnt), .Cycle_cnt(Cycle_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous read, data valid the cycle after IM_read.
  always @(posedge clk) if (IM_read) im_q <= mem[IM_address];
  assign instruction = im_q;

  function automatic int cls_of(logic [31:0] w);
    if (w[31]) return K_ILL;
    case (w[30:25])
      6'b100000:                               return K_ALU;
      6'b100010, 6'b101000, 6'b101100, 6'b101011: return K_IMM;
      6'b000010:                               return K_LD;
      6'b001010:                               return K_ST;
      default:                                 return K_ILL;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph <= PH_IDLE; m_pc <= '0; m_ir <= '0; m_ins <= '0; m_cyc <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_ph == PH_IDLE) m_ph <= 0;
      else if (m_ph == PH_HALT) m_ph <= PH_HALT;
      else if (m_ph == 1) begin m_ir <= mem[m_pc]; m_ph <= 2; end
      else if (m_ph == 2) m_ph <= (cls_of(m_ir) == K_ILL) ? PH_HALT : 3;
      else if (m_ph == 7) begin m_ph <= 0; m_pc <= m_pc + 1; m_ins <= m_ins + 1; end
      else m_ph <= m_ph + 1;
    end
  end

  // Strobe vector order: IM_enable IM_read IM_write rf_read alu_en DM_enable
  // DM_read DM_write dm_load rf_write wb_sel imm_sel halted
  function automatic logic [12:0] exp_strb(int p, int c);
    logic mem_op, in_slot;
    mem_op  = (c == K_LD) || (c == K_ST);
    in_slot = (p >= 2) && (p <= 7);
    return {p == 0 || p == 1, p == 0, 1'b0, p == 3, p == 4,
            (p == 5 || p == 6) && mem_op, p == 5 && c == K_LD, p == 5 && c == K_ST,
            p == 6 && c == K_LD, p == 7 && c != K_ST, in_slot && c == K_LD,
            in_slot && mem_op || in_slot && c == K_IMM, p == PH_HALT};
  endfunction

  function automatic logic [12:0] dut_strb();
    return {IM_enable, IM_read, IM_write, rf_read, alu_en, DM_enable, DM_read,
            DM_write, dm_load, rf_write, wb_sel, imm_sel, halted};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [5:0] op;
    case ($urandom_range(6))
      0: op = 6'b100000;
      1: op = 6'b100010;
      2: op = 6'b101000;
      3: op = 6'b101100;
      4: op = 6'b101011;
      5: op = 6'b000010;
      default: op = 6'b001010;
    endcase
    return {1'b0, op, 25'($urandom)};
  endfunction

  function automatic logic [31:0] rand_illegal();
    if ($urandom_range(1) == 0) return {1'b1, 31'($urandom)};
    return {1'b0, 6'b111111, 25'($urandom)};
  endfunction

  // Scoreboard: every falling edge, compare all outputs with the model.
  task automatic monitor();
    forever begin
      @(negedge clk);
      checks++;
      if (dut_strb() !== exp_strb(m_ph, cls_of(m_ir))) begin
        errors++;
        if (errors <= 20) $display("FAIL sb_strobes t=%0t phase=%0d got=%b exp=%b",
                                   $time, m_ph, dut_strb(), exp_strb(m_ph, cls_of(m_ir)));
      end
      checks++;
      if (IM_address !== m_pc) begin
        errors++;
        if (errors <= 20) $display("FAIL sb_pc t=%0t got=%0d exp=%0d", $time, IM_address, m_pc);
      end
      checks++;
      if (ir !== m_ir) begin
        errors++;
        if (errors <= 20) $display("FAIL sb_ir t=%0t got=%h exp=%h", $time, ir, m_ir);
      end
      checks++;
      if (Ins_cnt !== m_ins) begin
        errors++;
        if (errors <= 20) $display("FAIL sb_ins_cnt t=%0t got=%0d exp=%0d", $time, Ins_cnt, m_ins);
      end
      checks++;
      if (Cycle_cnt !== m_cyc) begin
        errors++;
        if (errors <= 20) $display("FAIL sb_cycle_cnt t=%0t got=%0d exp=%0d", $time, Cycle_cnt, m_cyc);
      end
    end
  endtask

  // Wait n rising edges, then settle 2 ns past the edge for sampling.
  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    edges(2);
    rst = 1'b1;  // next rising edge leaves IDLE for F0
  endtask

  task automatic fill_legal();
    for (int i = 0; i < 1024; i++) mem[i] = rand_legal();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    edges(3);
    checks++;
    if (dut_strb() !== 13'd0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0", dut_strb());
    end
    checks++;
    if (IM_address !== 10'd0 || ir !== 32'd0) begin
      errors++; $display("FAIL reset_pc_ir got pc=%0d ir=%h exp 0/0", IM_address, ir);
    end
    checks++;
    if (Ins_cnt !== 64'd0 || Cycle_cnt !== 128'd0) begin
      errors++; $display("FAIL reset_counters got ins=%0d cyc=%0d exp 0/0", Ins_cnt, Cycle_cnt);
    end
  endtask

  task automatic test_nop_stream();
    int pulses = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h4000_0000;
    apply_reset();
    for (int k = 1; k <= 25; k++) begin
      edges(1);
      if (IM_read) begin
        pulses++;
        checks++;
        if (IM_address !== 10'((k - 1) / 8) || (k - 1) % 8 != 0) begin
          errors++;
          $display("FAIL nop_fetch cycle=%0d got addr=%0d exp addr=%0d at slot start",
                   k, IM_address, (k - 1) / 8);
        end
      end
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL nop_pulses got=%0d exp=4", pulses); end
    checks++;
    if (Ins_cnt !== 64'd3 || Cycle_cnt !== 128'd25) begin
      errors++; $display("FAIL nop_counts got ins=%0d cyc=%0d exp 3/25", Ins_cnt, Cycle_cnt);
    end
  endtask

  task automatic test_mem_sequence();
    logic [7:0] rfw [3];
    logic [7:0] dme [3];
    logic [7:0] dmw [3];
    logic [7:0] dmr [3];
    logic [7:0] dml [3];
    logic [7:0] wbs [3];
    for (int i = 0; i < 1024; i++) mem[i] = 32'h4000_0000;
    mem[0] = {1'b0, 6'b100010, 25'h12345};
    mem[1] = {1'b0, 6'b001010, 25'h00abc};
    mem[2] = {1'b0, 6'b000010, 25'h1f00f};
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 8; k++) begin
        edges(1);
        rfw[s][k] = rf_write;  dme[s][k] = DM_enable; dmw[s][k] = DM_write;
        dmr[s][k] = DM_read;   dml[s][k] = dm_load;   wbs[s][k] = wb_sel;
      end
    end
    checks++;
    if ({rfw[0], rfw[1], rfw[2]} !== {8'h80, 8'h00, 8'h80}) begin
      errors++; $display("FAIL seq_rf_write got=%h%h%h exp=800080", rfw[0], rfw[1], rfw[2]);
    end
    checks++;
    if ({dme[0], dme[1], dmw[1]} !== {8'h00, 8'h60, 8'h20}) begin
      errors++; $display("FAIL seq_store got en0=%h en1=%h wr1=%h exp 00/60/20", dme[0], dme[1], dmw[1]);
    end
    checks++;
    if ({dmr[2], dml[2], dme[2]} !== {8'h20, 8'h40, 8'h60}) begin
      errors++; $display("FAIL seq_load got rd=%h ld=%h en=%h exp 20/40/60", dmr[2], dml[2], dme[2]);
    end
    checks++;
    if ({wbs[1], wbs[2]} !== {8'h00, 8'hfc}) begin
      errors++; $display("FAIL seq_wb_sel got st=%h ld=%h exp 00/fc", wbs[1], wbs[2]);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h4000_0000;
    mem[1] = 32'h8000_0000;
    apply_reset();
    edges(12);
    checks++;
    if (halted !== 1'b1 || Ins_cnt !== 64'd1 || Cycle_cnt !== 128'd12) begin
      errors++; $display("FAIL halt_bit31 got h=%b ins=%0d cyc=%0d exp 1/1/12", halted, Ins_cnt, Cycle_cnt);
    end
    edges(10);
    checks++;
    if (dut_strb() !== 13'd1 || IM_address !== 10'd1 || Ins_cnt !== 64'd1 || Cycle_cnt !== 128'd22) begin
      errors++;
      $display("FAIL halt_frozen got strb=%b pc=%0d ins=%0d cyc=%0d exp 1/1/1/22",
               dut_strb(), IM_address, Ins_cnt, Cycle_cnt);
    end
    mem[0] = {1'b0, 6'b111111, 25'h0};
    apply_reset();
    edges(4);
    checks++;
    if (halted !== 1'b1 || Ins_cnt !== 64'd0 || Cycle_cnt !== 128'd4) begin
      errors++; $display("FAIL halt_op3f got h=%b ins=%0d cyc=%0d exp 1/0/4", halted, Ins_cnt, Cycle_cnt);
    end
  endtask

  task automatic test_reset_mid_slot();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h4000_0000;
    mem[0] = {1'b0, 6'b001010, 25'h0};
    apply_reset();
    edges(6);
    checks++;
    if (DM_write !== 1'b1 || DM_enable !== 1'b1) begin
      errors++; $display("FAIL abort_m0 got wr=%b en=%b exp 1/1", DM_write, DM_enable);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (dut_strb() !== 13'd0 || IM_address !== 10'd0 || Cycle_cnt !== 128'd0) begin
      errors++;
      $display("FAIL abort_async got strb=%b pc=%0d cyc=%0d exp 0/0/0", dut_strb(), IM_address, Cycle_cnt);
    end
    edges(1);
    rst = 1'b1;
    edges(1);
    checks++;
    if (IM_read !== 1'b1 || IM_address !== 10'd0) begin
      errors++; $display("FAIL abort_restart got rd=%b pc=%0d exp 1/0", IM_read, IM_address);
    end
    edges(8);
  endtask

  task automatic test_random_program();
    fill_legal();
    for (int i = 24; i < 1024; i++) mem[i] = rand_illegal();
    apply_reset();
    edges(193);
    checks++;
    if (Ins_cnt !== 64'd24 || Cycle_cnt !== 128'd193 || IM_address !== 10'd24) begin
      errors++;
      $display("FAIL prog24 got ins=%0d cyc=%0d pc=%0d exp 24/193/24", Ins_cnt, Cycle_cnt, IM_address);
    end
    edges(4);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL prog24_halt got=%b exp=1", halted); end
  endtask

  task automatic test_pc_wrap();
    fill_legal();
    apply_reset();
    edges(1 + 8 * 1023);
    checks++;
    if (IM_address !== 10'd1023 || IM_read !== 1'b1) begin
      errors++; $display("FAIL wrap_last got pc=%0d rd=%b exp 1023/1", IM_address, IM_read);
    end
    edges(8);
    checks++;
    if (IM_address !== 10'd0 || IM_read !== 1'b1 || Ins_cnt !== 64'd1024 || Cycle_cnt !== 128'd8193) begin
      errors++;
      $display("FAIL wrap_zero got pc=%0d rd=%b ins=%0d cyc=%0d exp 0/1/1024/8193",
               IM_address, IM_read, Ins_cnt, Cycle_cnt);
    end
  endtask

  task automatic test_random_mix();
    for (int r = 0; r < 3; r++) begin
      int first_bad = 1024;
      int exp_ins;
      for (int i = 0; i < 1024; i++) begin
        mem[i] = ($urandom_range(19) == 0) ? rand_illegal() : rand_legal();
        if (first_bad == 1024 && cls_of(mem[i]) == K_ILL) first_bad = i;
      end
      apply_reset();
      edges(400);
      // Slot j fetches at edge 8j+1 and halts at edge 8j+4; 49 slots retire by edge 400.
      exp_ins = (first_bad < 49) ? first_bad : 49;
      checks++;
      if (halted !== (8 * first_bad + 4 <= 400) || Ins_cnt !== 64'(exp_ins)) begin
        errors++;
        $display("FAIL mix_round%0d got h=%b ins=%0d exp h=%b ins=%0d",
                 r, halted, Ins_cnt, (8 * first_bad + 4 <= 400), exp_ins);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_nop_stream();
    test_mem_sequence();
    test_halt();
    test_reset_mid_slot();
    test_random_program();
    test_pc_wrap();
    test_random_mix();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
